branch_predictor: RTL

Parametrised branch target buffer with per-entry saturating direction counters, queried by the IF stage every cycle and trained by the EX stage when a control-flow instruction resolves. It lets the 5-stage pipeline fetch predicted-taken targets early instead of always fetching PC+4 and flushing on every taken branch. It also produces the EX-stage mispredict and redirect signals and keeps performance counters.

---
 rtl/bp_defs.sv | 28 ++
 rtl/sat_counter.sv | 27 ++
 rtl/branch_predictor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bp_defs.sv
// rtl/bp_defs.sv - shared index/tag slicing and counter constants for the branch predictor
`ifndef BP_DEFS_SV
`define BP_DEFS_SV

// Table index: word-aligned PC bits just above the byte offset.
`define BP_IDX(pc, iw) pc[(iw)+1:2]
// Partial tag: the TAG_W bits directly above the index.
`define BP_TAG(pc, iw, tw) pc[(iw)+(tw)+1:(iw)+2]

package bp_defs;

    // Counter value written on allocation: lowest value that still predicts taken.
    function automatic int cnt_weak_taken(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    // Counter value after reset: highest value that still predicts not-taken.
    function automatic int cnt_weak_not_taken(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Entry record layout, most significant field first:
    //   valid | tag[TAG_W] | target[XLEN] | cnt[CNT_W] | jump
    localparam int ENTRY_FIELDS = 5;

endpackage

`endif

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down direction counter next-value logic
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    input  logic             en,
    output logic [CNT_W-1:0] next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Step toward the outcome, holding at either end of the range.
    always_comb begin
        next = cnt;
        if (en) begin
            if (inc && (cnt != CNT_MAX)) begin
                next = cnt + CNT_ONE;
            end else if (!inc && (cnt != CNT_MIN)) begin
                next = cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB with direction counters, EX mispredict/redirect and perf counters
`include "bp_defs.sv"

module branch_predictor
    import bp_defs::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            tbl_flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CNT_W-1:0] cnt;
        logic             jump;
    } entry_t;

    entry_t tbl [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [CNT_W-1:0] cnt_next;

    assign if_idx = `BP_IDX(if_pc, IDX_W);
    assign if_tag = `BP_TAG(if_pc, IDX_W, TAG_W);
    assign ex_idx = `BP_IDX(ex_pc, IDX_W);
    assign ex_tag = `BP_TAG(ex_pc, IDX_W, TAG_W);

    // Fetch-side lookup: no bypass, so same-cycle updates are not seen here.
    always_comb begin
        pred_hit    = tbl[if_idx].valid && (tbl[if_idx].tag == if_tag);
        pred_taken  = pred_hit && (tbl[if_idx].jump || tbl[if_idx].cnt[CNT_W-1]);
        pred_target = pred_taken ? tbl[if_idx].target : (if_pc + PC_STEP);
    end

    // EX-side resolution against the prediction that travelled down the pipe.
    always_comb begin
        ex_hit      = tbl[ex_idx].valid && (tbl[ex_idx].tag == ex_tag);
        mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                                   (ex_taken && (ex_pred_target != ex_target)));
        redirect_pc = ex_taken ? ex_target : (ex_pc + PC_STEP);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .cnt  (tbl[ex_idx].cnt),
        .inc  (ex_taken),
        .en   (ex_valid),
        .next (cnt_next)
    );

    // Table storage: flush beats training; misses allocate only on taken outcomes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid  <= 1'b0;
                tbl[i].tag    <= '0;
                tbl[i].target <= '0;
                tbl[i].cnt    <= CNT_WNT;
                tbl[i].jump   <= 1'b0;
            end
        end else if (tbl_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                tbl[ex_idx].cnt <= cnt_next;
                if (ex_taken) begin
                    tbl[ex_idx].target <= ex_target;
                    tbl[ex_idx].jump   <= ex_is_jump;
                end
            end else if (ex_taken) begin
                tbl[ex_idx].valid  <= 1'b1;
                tbl[ex_idx].tag    <= ex_tag;
                tbl[ex_idx].target <= ex_target;
                tbl[ex_idx].cnt    <= CNT_WT;
                tbl[ex_idx].jump   <= ex_is_jump;
            end
        end
    end

    // Performance counters keep running through flushes and wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (ex_valid) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end

endmodule
